// File: rtl/debounce.sv
// Input conditioner: two-flop synchronizer followed by a four-state filter FSM
// that emits a clean level plus single-cycle rise/fall strobes.
module debounce #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  output logic y,
  output logic rise,
  output logic fall
);

  typedef enum logic [1:0] {
    LOW,
    WAIT_HIGH,
    HIGH,
    WAIT_LOW
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             y_q;
  logic             rise_q;
  logic             fall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= LOW;
      cnt_q   <= '0;
      y_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q   <= a;
      s2_q   <= s1_q;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        LOW: begin
          if (s2_q) begin
            state_q <= WAIT_HIGH;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q   <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!s2_q) begin
            state_q <= LOW;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_MAX) begin
            state_q <= HIGH;
            y_q     <= 1'b1;
            rise_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
          end
        end
        HIGH: begin
          if (!s2_q) begin
            state_q <= WAIT_LOW;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q   <= '0;
          end
        end
        WAIT_LOW: begin
          if (s2_q) begin
            state_q <= HIGH;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_MAX) begin
            state_q <= LOW;
            y_q     <= 1'b0;
            fall_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= LOW;
          cnt_q   <= '0;
          y_q     <= 1'b0;
        end
      endcase
    end
  end

  assign y    = y_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: tb/tb_debounce.sv
// Bench for debounce: directed scenarios plus random bounce traffic, each
// checked against a run-length model of the filter.
module tb_debounce;

  localparam int unsigned SC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a   = 1'b0;
  logic y, rise, fall;

  int total = 0;
  int bad   = 0;

  debounce #(.STABLE_CYCLES(SC)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .y    (y),
    .rise (rise),
    .fall (fall)
  );

  always #5 clk = ~clk;

  // Model: a sample reaches the filter two edges after capture; y flips once
  // SC consecutive samples disagree with it.
  bit          pipe[$];
  bit          m_y, m_rise, m_fall;
  int unsigned run;

  always @(posedge clk) begin
    bit smp;
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (rst) begin
      pipe.delete();
      pipe.push_back(1'b0);
      pipe.push_back(1'b0);
      m_y = 1'b0;
      run = 0;
    end else begin
      smp = pipe.pop_front();
      pipe.push_back(a);
      if (smp != m_y) run++;
      else run = 0;
      if (run == SC) begin
        m_y = ~m_y;
        if (m_y) m_rise = 1'b1;
        else m_fall = 1'b1;
        run = 0;
      end
    end
  end

  task automatic drive(input logic av, input logic rv);
    @(posedge clk);
    #2;
    a   = av;
    rst = rv;
  endtask

  task automatic reset_low;
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
  endtask

  task automatic test_reset;
    int rise_at = -1;
    drive(1'b1, 1'b1);
    @(negedge clk);
    total++;
    if ({y, rise, fall} !== 3'b000) begin
      bad++;
      $display("FAIL reset_edge1: got y/rise/fall=%b exp 000", {y, rise, fall});
    end
    drive(1'b1, 1'b0);
    @(negedge clk);
    total++;
    if ({y, rise, fall} !== 3'b000) begin
      bad++;
      $display("FAIL reset_edge2: got y/rise/fall=%b exp 000", {y, rise, fall});
    end
    for (int k = 1; k <= 9; k++) begin
      drive(1'b1, 1'b0);
      @(negedge clk);
      total++;
      if ({y, rise, fall} !== {m_y, m_rise, m_fall}) begin
        bad++;
        $display("FAIL reset_model k=%0d: got %b exp %b", k, {y, rise, fall}, {m_y, m_rise, m_fall});
      end
      total++;
      if ({y, rise} !== {logic'(k >= 6), logic'(k == 6)}) begin
        bad++;
        $display("FAIL reset_latency k=%0d: got y/rise=%b exp %b", k, {y, rise}, {logic'(k >= 6), logic'(k == 6)});
      end
      if (rise && rise_at < 0) rise_at = k;
    end
    total++;
    if (rise_at != 6) begin
      bad++;
      $display("FAIL reset_rise_at: got %0d exp 6", rise_at);
    end
  endtask

  task automatic test_clean_press;
    int rise_at = -1, fall_at = -1, nr = 0, nf = 0;
    reset_low();
    for (int k = 0; k < 36; k++) begin
      drive(logic'(k < 20), 1'b0);
      @(negedge clk);
      total++;
      if ({y, rise, fall} !== {m_y, m_rise, m_fall}) begin
        bad++;
        $display("FAIL clean_model k=%0d: got %b exp %b", k, {y, rise, fall}, {m_y, m_rise, m_fall});
      end
      if (rise) begin nr++; if (rise_at < 0) rise_at = k; end
      if (fall) begin nf++; if (fall_at < 0) fall_at = k; end
    end
    total++;
    if (rise_at != 6 || nr != 1) begin
      bad++;
      $display("FAIL clean_rise: got at=%0d n=%0d exp at=6 n=1", rise_at, nr);
    end
    total++;
    if (fall_at != 26 || nf != 1) begin
      bad++;
      $display("FAIL clean_fall: got at=%0d n=%0d exp at=26 n=1", fall_at, nf);
    end
  endtask

  task automatic test_glitch;
    int nr = 0, nf = 0, ny = 0;
    reset_low();
    for (int k = 0; k < 16; k++) begin
      drive(logic'(k < 3), 1'b0);
      @(negedge clk);
      total++;
      if ({y, rise, fall} !== {m_y, m_rise, m_fall}) begin
        bad++;
        $display("FAIL glitch_model k=%0d: got %b exp %b", k, {y, rise, fall}, {m_y, m_rise, m_fall});
      end
      if (rise) nr++;
      if (fall) nf++;
      if (y) ny++;
    end
    total++;
    if (nr != 0 || nf != 0 || ny != 0) begin
      bad++;
      $display("FAIL glitch_quiet: got rises=%0d falls=%0d ycycles=%0d exp 0 0 0", nr, nf, ny);
    end
  endtask

  task automatic test_bounce;
    logic [5:0] pat = 6'b101101;
    int rise_at = -1, nr = 0;
    reset_low();
    for (int k = 0; k < 20; k++) begin
      drive((k < 6) ? pat[k] : 1'b1, 1'b0);
      @(negedge clk);
      total++;
      if ({y, rise, fall} !== {m_y, m_rise, m_fall}) begin
        bad++;
        $display("FAIL bounce_model k=%0d: got %b exp %b", k, {y, rise, fall}, {m_y, m_rise, m_fall});
      end
      if (rise) begin nr++; if (rise_at < 0) rise_at = k; end
    end
    total++;
    if (rise_at != 11 || nr != 1) begin
      bad++;
      $display("FAIL bounce_rise: got at=%0d n=%0d exp at=11 n=1", rise_at, nr);
    end
  endtask

  task automatic test_reset_mid;
    int rise_at = -1, nr = 0;
    reset_low();
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, logic'(k == 3));
      @(negedge clk);
      total++;
      if ({y, rise, fall} !== {m_y, m_rise, m_fall}) begin
        bad++;
        $display("FAIL rstmid_model k=%0d: got %b exp %b", k, {y, rise, fall}, {m_y, m_rise, m_fall});
      end
      if (k == 4) begin
        total++;
        if ({y, rise, fall} !== 3'b000) begin
          bad++;
          $display("FAIL rstmid_in_reset: got %b exp 000", {y, rise, fall});
        end
      end
      if (rise) begin nr++; if (rise_at < 0) rise_at = k; end
    end
    total++;
    if (rise_at != 10 || nr != 1) begin
      bad++;
      $display("FAIL rstmid_rise: got at=%0d n=%0d exp at=10 n=1", rise_at, nr);
    end
  endtask

  task automatic test_long_hold;
    int rise_at = -1, fall_at = -1, nr = 0, nf = 0;
    reset_low();
    for (int k = 0; k < 20; k++) begin
      drive(logic'(k < 4), 1'b0);
      @(negedge clk);
      total++;
      if ({y, rise, fall} !== {m_y, m_rise, m_fall}) begin
        bad++;
        $display("FAIL hold_model k=%0d: got %b exp %b", k, {y, rise, fall}, {m_y, m_rise, m_fall});
      end
      if (rise) begin nr++; if (rise_at < 0) rise_at = k; end
      if (fall) begin nf++; if (fall_at < 0) fall_at = k; end
    end
    total++;
    if (rise_at != 6 || nr != 1 || fall_at != 10 || nf != 1) begin
      bad++;
      $display("FAIL hold_edges: got rise@%0d x%0d fall@%0d x%0d exp rise@6 x1 fall@10 x1",
               rise_at, nr, fall_at, nf);
    end
  endtask

  task automatic test_random;
    logic        v = 1'b0;
    int unsigned len = 0;
    int          both = 0;
    reset_low();
    for (int k = 0; k < 600; k++) begin
      if (len == 0) begin
        v   = ~v;
        len = $urandom_range(1, 8);
      end
      len--;
      drive(v, 1'b0);
      @(negedge clk);
      total++;
      if ({y, rise, fall} !== {m_y, m_rise, m_fall}) begin
        bad++;
        $display("FAIL random_model k=%0d: got %b exp %b", k, {y, rise, fall}, {m_y, m_rise, m_fall});
      end
      if (rise && fall) both++;
    end
    total++;
    if (both != 0) begin
      bad++;
      $display("FAIL random_strobe_overlap: got %0d cycles exp 0", both);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_reset_mid();
    test_long_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
